// File: rtl/facto_pkg.sv
// Shared definitions for the factorial accelerator: register offsets,
// STATUS bit positions and the engine state encoding.
package facto_pkg;

  localparam logic [7:0] ADDR_OPSTART  = 8'h00;
  localparam logic [7:0] ADDR_OPCLEAR  = 8'h08;
  localparam logic [7:0] ADDR_STATUS   = 8'h10;
  localparam logic [7:0] ADDR_INTREN   = 8'h18;
  localparam logic [7:0] ADDR_OPERAND  = 8'h20;
  localparam logic [7:0] ADDR_RESULT_H = 8'h28;
  localparam logic [7:0] ADDR_RESULT_L = 8'h30;
  localparam logic [7:0] ADDR_CYCLES   = 8'h38;

  localparam int unsigned STATUS_DONE = 0;
  localparam int unsigned STATUS_BUSY = 1;
  localparam int unsigned STATUS_OVF  = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/facto_engine.sv
// Iterative factorial engine: one multiply per cycle counting the operand
// down to 2, with sticky overflow detection and a multiply counter.
module facto_engine
  import facto_pkg::*;
#(
  parameter int unsigned DW = 64
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic            clear,
  input  logic [DW-1:0]   operand,
  output logic [2*DW-1:0] acc,
  output logic            done,
  output logic            busy,
  output logic            ovf,
  output logic [63:0]     cycles
);

  localparam logic [DW-1:0]   CntOne  = DW'(1);
  localparam logic [DW-1:0]   CntLast = DW'(2);
  localparam logic [2*DW-1:0] AccOne  = (2*DW)'(1);

  state_e            state_q, state_d;
  logic [2*DW-1:0]   acc_q, acc_d;
  logic [DW-1:0]     cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic [63:0]       cycles_q, cycles_d;
  logic [3*DW-1:0]   prod;

  assign prod = {{DW{1'b0}}, acc_q} * {{(2*DW){1'b0}}, cnt_q};

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    cycles_d = cycles_q;
    // Clear has priority over everything, including a same-cycle start.
    if (clear) begin
      state_d  = IDLE;
      acc_d    = '0;
      cnt_d    = '0;
      ovf_d    = 1'b0;
      cycles_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            cnt_d    = operand;
            acc_d    = AccOne;
            ovf_d    = 1'b0;
            cycles_d = '0;
            state_d  = (operand <= CntOne) ? DONE : CALC;
          end
        end
        CALC: begin
          acc_d    = prod[2*DW-1:0];
          cnt_d    = cnt_q - CntOne;
          cycles_d = cycles_q + 64'd1;
          if (prod[3*DW-1:2*DW] != '0) begin
            ovf_d   = 1'b1;
            state_d = DONE;
          end else if (cnt_q == CntLast) begin
            state_d = DONE;
          end
        end
        DONE: ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      cycles_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      cycles_q <= cycles_d;
    end
  end

  assign acc    = acc_q;
  assign done   = (state_q == DONE);
  assign busy   = (state_q == CALC);
  assign ovf    = ovf_q;
  assign cycles = cycles_q;

endmodule

// File: rtl/facto_core_param.sv
// Memory-mapped factorial accelerator: bus decode, INTREN/OPERAND registers,
// read mux and interrupt gate around the factorial engine. Assumes DW <= 64.
module facto_core_param
  import facto_pkg::*;
#(
  parameter int unsigned DW = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        s_sel,
  input  logic        s_wr,
  input  logic [15:0] s_addr,
  input  logic [63:0] s_din,
  output logic [63:0] s_dout,
  output logic        interrupt
);

  logic [7:0]      addr;
  logic            wr_en, rd_en;
  logic            start, clear;
  logic [63:0]     intren_q, intren_d;
  logic [63:0]     operand_q, operand_d;
  logic [2*DW-1:0] acc;
  logic            done, busy, ovf;
  logic [63:0]     cycles;
  logic [63:0]     status;
  logic            unused_addr;

  assign addr        = s_addr[7:0];
  assign unused_addr = ^s_addr[15:8];
  assign wr_en       = s_sel & s_wr;
  assign rd_en       = s_sel & ~s_wr;

  assign start = wr_en && (addr == ADDR_OPSTART) && s_din[0];
  assign clear = wr_en && (addr == ADDR_OPCLEAR) && s_din[0];

  always_comb begin
    intren_d  = intren_q;
    operand_d = operand_q;
    if (wr_en) begin
      case (addr)
        ADDR_INTREN:  intren_d  = s_din;
        ADDR_OPERAND: operand_d = s_din;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      intren_q  <= '0;
      operand_q <= '0;
    end else begin
      intren_q  <= intren_d;
      operand_q <= operand_d;
    end
  end

  facto_engine #(
    .DW (DW)
  ) u_engine (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .clear   (clear),
    .operand (operand_q[DW-1:0]),
    .acc     (acc),
    .done    (done),
    .busy    (busy),
    .ovf     (ovf),
    .cycles  (cycles)
  );

  always_comb begin
    status              = '0;
    status[STATUS_DONE] = done;
    status[STATUS_BUSY] = busy;
    status[STATUS_OVF]  = ovf;
  end

  always_comb begin
    s_dout = '0;
    if (rd_en) begin
      case (addr)
        ADDR_STATUS:   s_dout = status;
        ADDR_INTREN:   s_dout = intren_q;
        ADDR_OPERAND:  s_dout = operand_q;
        ADDR_RESULT_H: s_dout = 64'(acc[2*DW-1:DW]);
        ADDR_RESULT_L: s_dout = 64'(acc[DW-1:0]);
        ADDR_CYCLES:   s_dout = cycles;
        default:       s_dout = '0;
      endcase
    end
  end

  assign interrupt = done & intren_q[0];

endmodule

// File: tb/tb_facto_core_param.sv
// Bench for facto_core_param: a transaction-level factorial model checked
// against the bus every cycle, plus directed reads with literal expectations.
module tb_facto_core_param;

  localparam logic [7:0] A_START = 8'h00;
  localparam logic [7:0] A_CLEAR = 8'h08;
  localparam logic [7:0] A_STAT  = 8'h10;
  localparam logic [7:0] A_INTEN = 8'h18;
  localparam logic [7:0] A_OPND  = 8'h20;
  localparam logic [7:0] A_RESH  = 8'h28;
  localparam logic [7:0] A_RESL  = 8'h30;
  localparam logic [7:0] A_CYC   = 8'h38;

  logic        clk = 1'b0;
  logic        reset_n, s_sel, s_wr, interrupt;
  logic [15:0] s_addr;
  logic [63:0] s_din, s_dout;
  logic        cmp_en = 1'b0;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  facto_core_param #(
    .DW (64)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .s_sel     (s_sel),
    .s_wr      (s_wr),
    .s_addr    (s_addr),
    .s_din     (s_din),
    .s_dout    (s_dout),
    .interrupt (interrupt)
  );

  // Model: a run is "active" from an accepted start until a clear; m_e counts
  // multiplies performed so far, capped at the number the run needs.
  logic        m_active;
  int          m_n, m_e;
  logic [63:0] m_intren, m_operand;
  logic [32:0] m_run;

  // {overflowed, multiplies needed} for n! held in 128 bits
  function automatic logic [32:0] fact_run(input int n);
    logic [255:0] p;
    int s;
    p = 256'd1;
    s = 0;
    for (int k = n; k >= 2; k--) begin
      p = p * 256'(k);
      s++;
      if (p[255:128] != '0) return {1'b1, 32'(s)};
    end
    return {1'b0, 32'(s)};
  endfunction

  function automatic logic [255:0] partial(input int n, input int e);
    logic [255:0] p;
    p = 256'd1;
    for (int i = 0; i < e; i++) p = p * 256'(n - i);
    return p;
  endfunction

  assign m_run = fact_run(m_n);

  function automatic logic m_done();
    return m_active && (m_e >= int'(m_run[31:0]));
  endfunction

  function automatic logic [63:0] exp_reg(input logic [7:0] a);
    logic [255:0] p;
    logic by;
    p  = m_active ? partial(m_n, m_e) : '0;
    by = m_active && (m_e < int'(m_run[31:0]));
    case (a)
      A_STAT:  return {61'd0, m_done() && m_run[32], by, m_done()};
      A_INTEN: return m_intren;
      A_OPND:  return m_operand;
      A_RESH:  return p[127:64];
      A_RESL:  return p[63:0];
      A_CYC:   return m_active ? 64'(m_e) : 64'd0;
      default: return 64'd0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (!reset_n) begin
      m_active  <= 1'b0;
      m_n       <= 0;
      m_e       <= 0;
      m_intren  <= '0;
      m_operand <= '0;
    end else begin
      if (m_active && (m_e < int'(m_run[31:0]))) m_e <= m_e + 1;
      if (s_sel && s_wr) begin
        case (s_addr[7:0])
          A_START: if (s_din[0] && !m_active) begin
            m_active <= 1'b1;
            m_n      <= int'(m_operand[31:0]);
            m_e      <= 0;
          end
          A_CLEAR: if (s_din[0]) m_active <= 1'b0;
          A_INTEN: m_intren <= s_din;
          A_OPND:  m_operand <= s_din;
          default: ;
        endcase
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("irq", 64'(interrupt), 64'(m_done() && m_intren[0]));
      if (s_sel && !s_wr) chk("rd_model", s_dout, exp_reg(s_addr[7:0]));
      else chk("dout_quiet", s_dout, 64'd0);
    end
  end

  task automatic bus_wr(input logic [7:0] a, input logic [63:0] d);
    @(posedge clk);
    #1;
    s_sel = 1'b1; s_wr = 1'b1; s_addr = {8'h00, a}; s_din = d;
  endtask

  task automatic bus_rd(input logic [7:0] a);
    @(posedge clk);
    #1;
    s_sel = 1'b1; s_wr = 1'b0; s_addr = {8'h00, a}; s_din = '0;
  endtask

  task automatic rd_lit(input logic [7:0] a, input logic [63:0] exp, input string name);
    bus_rd(a);
    #1;
    chk(name, s_dout, exp);
  endtask

  // Start a run and keep STATUS selected long enough for it to finish.
  task automatic run(input int n, input int wait_cycles);
    bus_wr(A_OPND, 64'(n));
    bus_wr(A_START, 64'd1);
    repeat (wait_cycles) bus_rd(A_STAT);
  endtask

  initial begin
    reset_n = 1'b0; s_sel = 1'b0; s_wr = 1'b0; s_addr = '0; s_din = '0;
    repeat (2) @(posedge clk);
    #1;
    cmp_en = 1'b1;
    rd_lit(A_STAT, 64'd0, "rst_status");
    rd_lit(A_RESL, 64'd0, "rst_resl");
    chk("rst_irq", 64'(interrupt), 64'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // 5! with exact done latency
    bus_wr(A_OPND, 64'd5);
    bus_wr(A_START, 64'd1);
    rd_lit(A_STAT, 64'h2, "n5_busy_first");
    repeat (2) bus_rd(A_STAT);
    rd_lit(A_STAT, 64'h2, "n5_busy_last");
    rd_lit(A_STAT, 64'h1, "n5_done");
    rd_lit(A_RESL, 64'd120, "n5_resl");
    rd_lit(A_RESH, 64'd0, "n5_resh");
    rd_lit(A_CYC, 64'd4, "n5_cycles");
    bus_wr(A_START, 64'd1);
    rd_lit(A_RESL, 64'd120, "n5_start_in_done_ignored");
    rd_lit(A_START, 64'd0, "opstart_reads_0");
    rd_lit(8'h40, 64'd0, "unmapped_0");
    bus_wr(8'h48, 64'hFFFF);
    bus_wr(A_CLEAR, 64'd1);
    rd_lit(A_STAT, 64'd0, "clear_status");

    // Trivial operands 0 and 1
    for (int n = 0; n < 2; n++) begin
      bus_wr(A_OPND, 64'(n));
      bus_wr(A_START, 64'd1);
      rd_lit(A_STAT, 64'h1, "n01_done");
      rd_lit(A_RESL, 64'd1, "n01_resl");
      rd_lit(A_CYC, 64'd0, "n01_cycles");
      bus_wr(A_CLEAR, 64'd1);
    end

    run(20, 22);
    rd_lit(A_RESL, 64'h21C3677C82B40000, "n20_resl");
    rd_lit(A_RESH, 64'd0, "n20_resh");
    rd_lit(A_STAT, 64'h1, "n20_status");
    bus_wr(A_CLEAR, 64'd1);

    run(34, 36);
    rd_lit(A_STAT, 64'h1, "n34_status");
    bus_rd(A_RESH);
    #1;
    chk("n34_resh_nonzero", 64'(s_dout != 64'd0), 64'd1);
    bus_wr(A_CLEAR, 64'd1);

    run(35, 36);
    rd_lit(A_STAT, 64'h5, "n35_ovf_status");
    rd_lit(A_CYC, 64'd31, "n35_cycles");
    bus_wr(A_CLEAR, 64'd1);

    // Abort mid-run; a start during CALC is ignored
    run(30, 3);
    bus_wr(A_START, 64'd1);
    bus_rd(A_STAT);
    bus_wr(A_CLEAR, 64'd1);
    rd_lit(A_STAT, 64'd0, "abort_status");
    rd_lit(A_RESL, 64'd0, "abort_resl");
    rd_lit(A_RESH, 64'd0, "abort_resh");
    rd_lit(A_CYC, 64'd0, "abort_cycles");
    repeat (3) bus_rd(A_STAT);
    rd_lit(A_OPND, 64'd30, "abort_operand_kept");

    // Interrupt; operand rewritten during CALC does not affect the run
    bus_wr(A_INTEN, 64'd1);
    bus_wr(A_OPND, 64'd3);
    bus_wr(A_START, 64'd1);
    bus_wr(A_OPND, 64'd9);
    rd_lit(A_STAT, 64'h2, "n3_busy");
    rd_lit(A_STAT, 64'h1, "n3_done");
    chk("n3_irq_rise", 64'(interrupt), 64'd1);
    rd_lit(A_RESL, 64'd6, "n3_resl");
    rd_lit(A_OPND, 64'd9, "n3_operand_rw");
    bus_wr(A_INTEN, 64'd0);
    bus_rd(A_STAT);
    chk("irq_masked", 64'(interrupt), 64'd0);
    bus_wr(A_INTEN, 64'd1);
    bus_rd(A_STAT);
    chk("irq_unmasked", 64'(interrupt), 64'd1);
    bus_wr(A_CLEAR, 64'd1);
    bus_rd(A_STAT);
    chk("irq_cleared", 64'(interrupt), 64'd0);

    // Reset during CALC
    run(10, 3);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    s_sel = 1'b1; s_wr = 1'b0; s_addr = {8'h00, A_STAT};
    @(posedge clk);
    #1;
    chk("rst_mid_status", s_dout, 64'd0);
    chk("rst_mid_irq", 64'(interrupt), 64'd0);
    s_addr = {8'h00, A_INTEN};
    #1;
    chk("rst_mid_intren", s_dout, 64'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    s_sel = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/facto_core_param.md
# facto_core_param

Parametrised memory-mapped factorial accelerator. It is the next-generation factorial core on the team's 64-bit slave bus. A host writes an operand and a start command; an iterative multiply engine computes operand! into a 2·DW-bit result. The block adds a busy flag, sticky overflow detection, a cycle counter, and a mid-operation abort. It sits behind the bus decoder as a slave peripheral and drives one level-sensitive interrupt line.

## Interface
Parameters:
- DW, 64: operand width; result is 2·DW bits, split into RESULT_H and RESULT_L.

Ports:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  synchronous, active-low reset.
- s_sel  in  1  slave select.
- s_wr  in  1  1 = write, 0 = read; valid with s_sel.
- s_addr  in  16  byte address; only s_addr[7:0] is decoded.
- s_din  in  64  write data.
- s_dout  out  64  read data.
- interrupt  out  1  level interrupt = STATUS.done & INTREN[0].

## Operation
- Register map (offset, access):
  - 0x00 OPSTART (W)
  - 0x08 OPCLEAR (W)
  - 0x10 STATUS (R)
  - 0x18 INTREN (RW)
  - 0x20 OPERAND (RW)
  - 0x28 RESULT_H (R)
  - 0x30 RESULT_L (R)
  - 0x38 CYCLES (R)
- Unmapped offsets read 0; writes to them are ignored.
- STATUS bits: bit0 done, bit1 busy, bit2 overflow; all other bits read 0.
- OPSTART and OPCLEAR are command strobes. Only bit0 is acted on; they read back as 0.
- FSM states IDLE, CALC, DONE:
  - IDLE, OPSTART bit0 = 1: latch the operand (low DW bits of OPERAND) into cnt; set acc = 1; clear overflow and CYCLES.
    - If operand ≤ 1 → DONE.
    - Otherwise → CALC.
  - CALC, each cycle:
    - prod = acc × cnt, 3·DW bits wide.
    - acc ← prod[2DW-1:0]; cnt ← cnt − 1; CYCLES += 1.
    - If prod[3DW-1:2DW] ≠ 0: set the sticky overflow bit and go to DONE.
    - Else if cnt == 2 (last multiply): go to DONE.
  - DONE: hold. Leave only on OPCLEAR. OPSTART is ignored.
- OPSTART in CALC or DONE is ignored.
- OPCLEAR in any state: go to IDLE and clear acc, RESULT_H/L, STATUS, and CYCLES. This aborts a calculation in flight.
  - OPERAND and INTREN keep their values.
- OPSTART and OPCLEAR in the same cycle: the clear wins, and no start occurs.
- OPERAND writes during CALC update the register only; the calculation uses the latched cnt.
- RESULT_H = acc[2DW-1:DW] and RESULT_L = acc[DW-1:0], zero-extended to 64 bits when DW < 64.
- Results are valid when done = 1. During CALC they show intermediate values.

## Timing
- Writes take effect on the clk edge where s_sel & s_wr are high.
- Reads are combinational: s_dout = selected register when s_sel & ~s_wr, else 0.
- Start accepted at edge T:
  - busy = 1 from T+1.
  - For operand n ≥ 2: done = 1 and busy = 0 at T+1+(n−1); CYCLES = n−1.
  - For operand n ≤ 1: done = 1 at T+1; result = 1; CYCLES = 0.
- When overflow occurs, the core stops after the overflowing multiply; CYCLES counts that multiply.
- interrupt rises in the same cycle as done and stays high until OPCLEAR or until INTREN[0] is cleared.
- Reset values: all registers 0, state IDLE, s_dout 0 when unselected, interrupt 0.
- A reset during CALC aborts the calculation; the same reset values apply at the next edge.

## Structure
- Package facto_pkg holds:
  - register offset localparams (ADDR_OPSTART … ADDR_CYCLES);
  - STATUS bit indices;
  - the state enum {IDLE, CALC, DONE}.
- Sub-module facto_engine holds the FSM, acc, cnt, multiplier, overflow, and CYCLES.
  - Inputs: start, clear, operand.
  - Outputs: acc, done, busy, ovf, cycles.
- The top level holds address decode, the INTREN/OPERAND registers, the read mux, and the interrupt gate.

## Test plan
- Operand 5, start → RESULT_L = 120, RESULT_H = 0, STATUS = 0x1, CYCLES = 4; done 5 cycles after the start edge.
- Operand 0, then operand 1 (OPCLEAR between runs) → each gives RESULT_L = 1, CYCLES = 0, done one cycle after start.
- Operand 20 → RESULT_L = 0x21C3677C82B40000, RESULT_H = 0, no overflow.
- DW = 64, operand 34 → no overflow, RESULT_H ≠ 0. Operand 35 → STATUS = 0x5 (done + overflow).
- Operand 30; OPCLEAR on cycle 5 of CALC, also OPSTART together with OPCLEAR → STATUS = 0, results 0, CYCLES = 0, state IDLE, no start.
- INTREN = 1, operand 3 → interrupt rises with done and holds; OPCLEAR drops it. Repeat with reset_n = 0 mid-CALC → all outputs 0 on the next edge.
